// File: rtl/vga_fb_writer.sv
// Pixel-stream to framebuffer BRAM writer: one 32-bit word per pixel, row-major, byte-addressed.
// Writes the blanking colour word once after reset, then tracks frame/line markers and flags framing errors.
module vga_fb_writer #(
    parameter int H_RES = 256,
    parameter int V_RES = 144,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tuser,
    input  logic             s_tlast,
    input  logic [31:0]      blank_color,
    output logic [31:0]      bram_addr,
    output logic [31:0]      bram_din,
    output logic [3:0]       bram_we,
    output logic             bram_en,
    output logic             frame_done,
    output logic             sof_err,
    output logic             eol_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [X_W-1:0]   X_LAST     = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(V_RES - 1);
    localparam logic [X_W-1:0]   X_ZERO     = {X_W{1'b0}};
    localparam logic [X_W-1:0]   X_ONE      = {{(X_W-1){1'b0}}, 1'b1};
    localparam logic [Y_W-1:0]   Y_ZERO     = {Y_W{1'b0}};
    localparam logic [Y_W-1:0]   Y_ONE      = {{(Y_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      BLANK_ADDR = 32'((H_RES * V_RES + 1) * 4);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_BLANK    = 2'd1,
        ST_WAIT_SOF = 2'd2,
        ST_WRITE    = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [X_W-1:0]   x_r, x_s;
    logic [Y_W-1:0]   y_r, y_s;
    logic             s_tready_r, s_tready_s;
    logic [31:0]      bram_addr_r, addr_s;
    logic [31:0]      bram_din_r, din_s;
    logic             bram_en_r, wr_s;
    logic             frame_done_r, fd_s;
    logic             sof_err_r, sof_s;
    logic             eol_err_r, eol_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic             beat_s;
    logic             x_at_end_s;
    logic [31:0]      pix_addr_s;

    // Next-state, coordinate and write-command decode for the current cycle.
    always_comb begin
        state_s    = state_r;
        x_s        = x_r;
        y_s        = y_r;
        wr_s       = 1'b0;
        addr_s     = 32'd0;
        din_s      = s_tdata;
        fd_s       = 1'b0;
        sof_s      = 1'b0;
        eol_s      = 1'b0;
        beat_s     = s_tvalid && s_tready_r;
        x_at_end_s = (x_r == X_LAST);
        pix_addr_s = (32'(x_r) + 32'(y_r) * 32'(H_RES)) << 2;

        case (state_r)
            ST_INIT: begin
                state_s = ST_BLANK;
            end
            ST_BLANK: begin
                wr_s    = 1'b1;
                addr_s  = BLANK_ADDR;
                din_s   = blank_color;
                state_s = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (beat_s && s_tuser) begin
                    wr_s    = 1'b1;
                    addr_s  = 32'd0;
                    x_s     = X_ONE;
                    y_s     = Y_ZERO;
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_WAIT_SOF;
                end
            end
            ST_WRITE: begin
                if (!beat_s) begin
                    state_s = ST_WRITE;
                end else if (s_tuser) begin
                    // A fresh SOF restarts the frame: this beat becomes pixel (0,0).
                    wr_s   = 1'b1;
                    sof_s  = 1'b1;
                    addr_s = 32'd0;
                    x_s    = X_ONE;
                    y_s    = Y_ZERO;
                end else begin
                    wr_s   = 1'b1;
                    addr_s = pix_addr_s;
                    eol_s  = x_at_end_s != s_tlast;
                    if (x_at_end_s || s_tlast) begin
                        x_s = X_ZERO;
                        if (y_r == Y_LAST) begin
                            y_s     = Y_ZERO;
                            fd_s    = 1'b1;
                            state_s = ST_WAIT_SOF;
                        end else begin
                            y_s = y_r + Y_ONE;
                        end
                    end else begin
                        x_s = x_r + X_ONE;
                    end
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase

        s_tready_s = (state_s == ST_WAIT_SOF) || (state_s == ST_WRITE);

        if ((sof_s || eol_s) && (err_cnt_r != CNT_MAX)) begin
            err_cnt_s = err_cnt_r + CNT_ONE;
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // State, coordinates and all registered outputs; reset drops any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_INIT;
            x_r          <= X_ZERO;
            y_r          <= Y_ZERO;
            s_tready_r   <= 1'b0;
            bram_addr_r  <= 32'd0;
            bram_din_r   <= 32'd0;
            bram_en_r    <= 1'b0;
            frame_done_r <= 1'b0;
            sof_err_r    <= 1'b0;
            eol_err_r    <= 1'b0;
            err_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            x_r          <= x_s;
            y_r          <= y_s;
            s_tready_r   <= s_tready_s;
            bram_addr_r  <= addr_s;
            bram_din_r   <= din_s;
            bram_en_r    <= wr_s;
            frame_done_r <= fd_s;
            sof_err_r    <= sof_s;
            eol_err_r    <= eol_s;
            err_cnt_r    <= err_cnt_s;
        end
    end

    assign s_tready   = s_tready_r;
    assign bram_addr  = bram_addr_r;
    assign bram_din   = bram_din_r;
    assign bram_en    = bram_en_r;
    assign bram_we    = bram_en_r ? 4'hF : 4'h0;
    assign frame_done = frame_done_r;
    assign sof_err    = sof_err_r;
    assign eol_err    = eol_err_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed self-checking bench for vga_fb_writer: blank write, full frame, pre-SOF discard,
// line-length and SOF errors, stalls and mid-line reset.
module tb_vga_fb_writer;

    logic        clk;
    logic        reset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tuser;
    logic        s_tlast;
    logic [31:0] blank_color;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic [3:0]  bram_we;
    logic        bram_en;
    logic        frame_done;
    logic        sof_err;
    logic        eol_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    int mon_wr = 0;
    int mon_fd = 0;

    vga_fb_writer #(.H_RES(256), .V_RES(144), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tuser    (s_tuser),
        .s_tlast    (s_tlast),
        .blank_color(blank_color),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_we    (bram_we),
        .bram_en    (bram_en),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .eol_err    (eol_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts BRAM writes and frame_done pulses over the whole run.
    always @(negedge clk) begin
        if (bram_en === 1'b1) mon_wr = mon_wr + 1;
        if (frame_done === 1'b1) mon_fd = mon_fd + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic beat(input logic [31:0] d, input logic u, input logic l);
        @(negedge clk);
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        blank_color = 32'h00FF00FF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (s_tready !== 1'b0 || bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== 32'd0 ||
            frame_done !== 1'b0 || sof_err !== 1'b0 || eol_err !== 1'b0 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: tready=%b en=%b we=%h addr=%h fd=%b se=%b ee=%b cnt=%0d, required all 0",
                     s_tready, bram_en, bram_we, bram_addr, frame_done, sof_err, eol_err, err_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bram_en !== 1'b0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL init_cycle: en=%b tready=%b, required en=0 tready=0", bram_en, s_tready);
        end
        @(posedge clk);
        #1;
        total++;
        if (bram_en !== 1'b1 || bram_we !== 4'hF || bram_addr !== 32'h00024004 ||
            bram_din !== 32'h00FF00FF || s_tready !== 1'b1) begin
            bad++;
            $display("FAIL blank_write: en=%b we=%h addr=%h din=%h tready=%b, required 1 F 00024004 00FF00FF 1",
                     bram_en, bram_we, bram_addr, bram_din, s_tready);
        end
        @(posedge clk);
        #1;
        total++;
        if (bram_en !== 1'b0 || bram_we !== 4'h0) begin
            bad++;
            $display("FAIL blank_once: en=%b we=%h, required 0 0", bram_en, bram_we);
        end
    endtask

    task automatic test_full_frame();
        int w0;
        int fd0;
        int nprint;
        w0 = mon_wr;
        fd0 = mon_fd;
        nprint = 0;
        for (int idx = 0; idx < 36864; idx++) begin
            beat(32'(idx), (idx == 0), ((idx % 256) == 255));
            total++;
            if (bram_en !== 1'b1 || bram_we !== 4'hF || bram_addr !== 32'(idx * 4) || bram_din !== 32'(idx) ||
                frame_done !== (idx == 36863) || eol_err !== 1'b0 || sof_err !== 1'b0) begin
                bad++;
                if (nprint < 10) begin
                    nprint++;
                    $display("FAIL frame_pixel %0d: en=%b addr=%h din=%h fd=%b ee=%b se=%b, required 1 %h %h %b 0 0",
                             idx, bram_en, bram_addr, bram_din, frame_done, eol_err, sof_err,
                             32'(idx * 4), 32'(idx), (idx == 36863));
                end
            end
        end
        total++;
        if (bram_addr !== 32'h00023FFC || bram_din !== 32'd36863 || frame_done !== 1'b1) begin
            bad++;
            $display("FAIL frame_last: addr=%h din=%0d fd=%b, required 00023FFC 36863 1", bram_addr, bram_din, frame_done);
        end
        idle();
        total++;
        if (bram_en !== 1'b0 || frame_done !== 1'b0 || s_tready !== 1'b1 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL frame_after: en=%b fd=%b tready=%b cnt=%0d, required 0 0 1 0", bram_en, frame_done, s_tready, err_cnt);
        end
        total++;
        if (mon_wr - w0 !== 36864 || mon_fd - fd0 !== 1) begin
            bad++;
            $display("FAIL frame_counts: writes=%0d fd_pulses=%0d, required 36864 1", mon_wr - w0, mon_fd - fd0);
        end
    endtask

    task automatic test_pre_sof();
        for (int i = 0; i < 5; i++) begin
            beat(32'hBAD0_0000 + 32'(i), 1'b0, (i == 2));
            total++;
            if (bram_en !== 1'b0 || eol_err !== 1'b0 || sof_err !== 1'b0) begin
                bad++;
                $display("FAIL pre_sof_discard %0d: en=%b ee=%b se=%b, required 0 0 0", i, bram_en, eol_err, sof_err);
            end
        end
        beat(32'h0000_00A0, 1'b1, 1'b0);
        total++;
        if (bram_en !== 1'b1 || bram_addr !== 32'd0 || bram_din !== 32'h0000_00A0 || sof_err !== 1'b0) begin
            bad++;
            $display("FAIL sof_first: en=%b addr=%h din=%h se=%b, required 1 0 A0 0", bram_en, bram_addr, bram_din, sof_err);
        end
    endtask

    task automatic test_eol_err();
        for (int y = 0; y < 3; y++) begin
            for (int x = (y == 0) ? 1 : 0; x < 256; x++) begin
                beat(32'(y * 256 + x), 1'b0, (x == 255));
            end
        end
        total++;
        if (err_cnt !== 8'd0 || bram_addr !== 32'h00000BFC || eol_err !== 1'b0) begin
            bad++;
            $display("FAIL lines_0_2: cnt=%0d addr=%h ee=%b, required 0 00000BFC 0", err_cnt, bram_addr, eol_err);
        end
        for (int x = 0; x < 100; x++) begin
            beat(32'(768 + x), 1'b0, (x == 99));
        end
        total++;
        if (eol_err !== 1'b1 || bram_en !== 1'b1 || bram_addr !== 32'h00000D8C || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL eol_short: ee=%b en=%b addr=%h fd=%b, required 1 1 00000D8C 0", eol_err, bram_en, bram_addr, frame_done);
        end
        beat(32'h0000_4000, 1'b0, 1'b0);
        total++;
        if (bram_addr !== 32'h00001000 || bram_din !== 32'h0000_4000 || eol_err !== 1'b0 || err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL eol_next: addr=%h din=%h ee=%b cnt=%0d, required 00001000 00004000 0 1",
                     bram_addr, bram_din, eol_err, err_cnt);
        end
    endtask

    task automatic test_sof_err();
        for (int x = 1; x < 10; x++) begin
            beat(32'(x), 1'b0, 1'b0);
        end
        total++;
        if (bram_addr !== 32'h00001024) begin
            bad++;
            $display("FAIL pre_sof_mid: addr=%h, required 00001024", bram_addr);
        end
        beat(32'h5050_5050, 1'b1, 1'b0);
        total++;
        if (sof_err !== 1'b1 || bram_en !== 1'b1 || bram_addr !== 32'd0 || bram_din !== 32'h5050_5050 || err_cnt !== 8'd2) begin
            bad++;
            $display("FAIL sof_mid: se=%b en=%b addr=%h din=%h cnt=%0d, required 1 1 0 50505050 2",
                     sof_err, bram_en, bram_addr, bram_din, err_cnt);
        end
        beat(32'h0000_0001, 1'b0, 1'b0);
        total++;
        if (sof_err !== 1'b0 || bram_addr !== 32'h00000004) begin
            bad++;
            $display("FAIL sof_next: se=%b addr=%h, required 0 00000004", sof_err, bram_addr);
        end
        beat(32'h0000_7777, 1'b1, 1'b1);
        total++;
        if (sof_err !== 1'b1 || eol_err !== 1'b0 || bram_addr !== 32'd0 || err_cnt !== 8'd3) begin
            bad++;
            $display("FAIL sof_over_eol: se=%b ee=%b addr=%h cnt=%0d, required 1 0 0 3", sof_err, eol_err, bram_addr, err_cnt);
        end
    endtask

    task automatic test_stall_and_midreset();
        int x;
        logic v;
        x = 1;
        for (int i = 0; i < 30; i++) begin
            v = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            s_tdata  = 32'h0000_0C00 + 32'(i);
            s_tuser  = 1'b0;
            s_tlast  = 1'b0;
            s_tvalid = v;
            @(posedge clk);
            #1;
            total++;
            if (v) begin
                if (bram_en !== 1'b1 || bram_addr !== 32'(x * 4) || bram_din !== 32'h0000_0C00 + 32'(i)) begin
                    bad++;
                    $display("FAIL stall_beat %0d: en=%b addr=%h din=%h, required 1 %h %h",
                             i, bram_en, bram_addr, bram_din, 32'(x * 4), 32'h0000_0C00 + 32'(i));
                end
                x++;
            end else begin
                if (bram_en !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_gap %0d: en=%b, required 0", i, bram_en);
                end
            end
        end
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD_BEEF;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== 32'd0 || bram_din !== 32'd0 ||
            s_tready !== 1'b0 || err_cnt !== 8'd0 || sof_err !== 1'b0 || eol_err !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_now: en=%b we=%h addr=%h din=%h tready=%b cnt=%0d, required all 0",
                     bram_en, bram_we, bram_addr, bram_din, s_tready, err_cnt);
        end
        @(posedge clk);
        #1;
        total++;
        if (bram_en !== 1'b0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_hold: en=%b tready=%b, required 0 0", bram_en, s_tready);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        blank_color = 32'h1234_5678;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bram_en !== 1'b0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL reinit_cycle: en=%b tready=%b, required 0 0", bram_en, s_tready);
        end
        @(posedge clk);
        #1;
        total++;
        if (bram_en !== 1'b1 || bram_addr !== 32'h00024004 || bram_din !== 32'h1234_5678 || s_tready !== 1'b1) begin
            bad++;
            $display("FAIL reinit_blank: en=%b addr=%h din=%h tready=%b, required 1 00024004 12345678 1",
                     bram_en, bram_addr, bram_din, s_tready);
        end
        beat(32'h0000_0099, 1'b0, 1'b0);
        total++;
        if (bram_en !== 1'b0) begin
            bad++;
            $display("FAIL reinit_discard: en=%b, required 0", bram_en);
        end
        beat(32'h0000_0042, 1'b1, 1'b0);
        total++;
        if (bram_en !== 1'b1 || bram_addr !== 32'd0 || bram_din !== 32'h0000_0042 || sof_err !== 1'b0) begin
            bad++;
            $display("FAIL reinit_sof: en=%b addr=%h din=%h se=%b, required 1 0 42 0", bram_en, bram_addr, bram_din, sof_err);
        end
    endtask

    initial begin
        reset       = 1'b0;
        s_tdata     = 32'd0;
        s_tvalid    = 1'b0;
        s_tuser     = 1'b0;
        s_tlast     = 1'b0;
        blank_color = 32'd0;
        test_reset();
        test_full_frame();
        test_pre_sof();
        test_eol_err();
        test_sof_err();
        test_stall_and_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
